river_crossing_checker: RTL and testbench
=========================================

Name: river_crossing_checker

Overview:
Parametrised move-validating state machine for the generalised missionaries-and-cannibals puzzle, with N_PAIRS of each group and boat capacity BOAT_CAP.
- An external source (testbench, switch interface or solver) presents boat loads over a valid/ready handshake.
- The block tracks bank occupancy and boat side, enforces capacity, availability and safety rules, counts moves, and flags finish or the first rule violation.

Parameters:
N_PAIRS, 3, missionaries per side and cannibals per side at start (1..15)
BOAT_CAP, 2, maximum passengers per crossing (1..2*N_PAIRS)
CNT_W, 6, move counter width
HIST_DEPTH, 16, undo history depth; used only with RCC_UNDO_EN
(localparam W = $clog2(N_PAIRS+1), the width of the count ports)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
move_valid  in  1  move offered
move_ready  out  1  block can accept a move
move_m  in  W  missionaries in the boat
move_c  in  W  cannibals in the boat
missionary_left  out  W  missionaries on the left bank
cannibal_left  out  W  cannibals on the left bank
boat_side  out  1  0 = left bank, 1 = right bank
move_count  out  CNT_W  number of accepted legal moves, saturating
finish  out  1  everyone is on the right bank
error  out  1  an illegal move was offered
err_code  out  2  0 none, 1 capacity, 2 shortage, 3 unsafe

Behaviour:
- Reset is sampled on posedge clk when reset==0. It is checked first and overrides all other activity, including mid-game.
- Reset values: missionary_left=N_PAIRS, cannibal_left=N_PAIRS, boat_side=0, move_count=0, finish=0, error=0, err_code=0, state=PLAY.
- States:
  - PLAY: move_ready=1.
  - DONE: move_ready=0, finish=1.
  - FAIL: move_ready=0, error=1.
  - DONE and FAIL are held until reset.
- Acceptance: a move is accepted when move_valid && move_ready at a clock edge. All outputs update on that same edge (1-cycle latency). move_ready is a pure function of the state.
- Departing bank is the left bank if boat_side==0, else the right bank. Right-bank counts are N_PAIRS minus left counts.
- Checks run on the accepted move. The first failing check in this priority order sets err_code:
  1. Capacity: move_m+move_c==0, or move_m+move_c>BOAT_CAP. Compute the sum at W+1 bits so it cannot overflow.
  2. Shortage: move_m or move_c exceeds the corresponding count on the departing bank.
  3. Unsafe: on either bank after the move, missionaries>0 and cannibals>missionaries.
- Illegal move: bank counts, boat_side and move_count are unchanged. State goes to FAIL, error=1, err_code is set.
- Legal move:
  - The moving group is subtracted from the departing bank and added to the other bank.
  - boat_side toggles.
  - move_count increments and saturates at 2^CNT_W-1.
  - If both left counts become 0, state goes to DONE and finish=1 on the same edge.
- move_valid while move_ready==0: ignored, no state change.
- move_m and move_c are don't-care when move_valid==0.

Optional Feature:
Macro RCC_UNDO_EN.
- With the macro defined:
  - Adds input undo (1 bit).
  - Adds a LIFO of HIST_DEPTH entries holding {move_m, move_c} of each accepted legal move. When the LIFO is full, a push overwrites the oldest entry (circular).
- undo in PLAY with a non-empty history:
  - Pops the last entry.
  - Moves that group back to the bank it departed from.
  - Toggles boat_side.
  - Decrements move_count, with a floor of 0.
- undo in PLAY with empty history: ignored.
- undo in FAIL: clears error and err_code, returns to PLAY, no pop.
- undo in DONE: ignored.
- undo has priority over a move: move_ready = state==PLAY && !undo.
- Without the macro: no undo port, no history storage, behaviour exactly as above.

Test Plan:
- Classic solution, N_PAIRS=3, BOAT_CAP=2. Moves (m,c): (0,2),(0,1),(0,2),(0,1),(2,0),(1,1),(2,0),(0,1),(0,2),(0,1),(0,2). Required after the 11th move: left=0/0, boat_side=1, move_count=11, finish=1, move_ready=0, error=0.
- Capacity: first move (2,1). Required: error=1, err_code=1, left=3/3, boat_side=0, move_count=0. A later (0,0) after a reset also gives err_code=1.
- Unsafe: first move (1,0), which would leave 2M/3C on the left. Required: err_code=3, counts unchanged.
- Shortage: move (0,2), then move (1,0) from the right bank. Required: err_code=2, left=3/1, move_count=1.
- Reset and backpressure: hold move_valid=1 with (0,1) in DONE for 5 cycles; no output changes. Drive reset=0 for one cycle mid-game after 4 moves; all outputs return to reset values on that edge.
- Undo (RCC_UNDO_EN): moves (0,2),(0,1), then undo. Required: left=3/1, boat_side=1, move_count=1. Then (1,0) gives err_code=2; undo clears it, state returns to PLAY, counts unchanged.

Source files
------------

// File: rtl/river_crossing_checker.sv
// river_crossing_checker: validates boat moves for N_PAIRS missionaries/cannibals; RCC_UNDO_EN adds undo with a move-history LIFO
module river_crossing_checker #(
  parameter int N_PAIRS = 3,
  parameter int BOAT_CAP = 2,
  parameter int CNT_W = 6,
  parameter int HIST_DEPTH = 16,
  localparam int W = $clog2(N_PAIRS + 1)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef RCC_UNDO_EN
  input  logic             undo,
`endif
  input  logic             move_valid,
  output logic             move_ready,
  input  logic [W-1:0]     move_m,
  input  logic [W-1:0]     move_c,
  output logic [W-1:0]     missionary_left,
  output logic [W-1:0]     cannibal_left,
  output logic             boat_side,
  output logic [CNT_W-1:0] move_count,
  output logic             finish,
  output logic             error,
  output logic [1:0]       err_code
);
  localparam logic [W-1:0] NP = W'(N_PAIRS);
  typedef enum logic [1:0] {PLAY, DONE, FAIL} state_t;
  state_t state;
  logic [W-1:0] dep_m, dep_c, nl_m, nl_c, nr_m, nr_c, um, uc;
  logic [W:0] sum;
  logic cap_bad, short_bad, unsafe_bad, legal, take, undo_pop, undo_clr;
  always_comb begin
    dep_m = boat_side ? NP - missionary_left : missionary_left;
    dep_c = boat_side ? NP - cannibal_left : cannibal_left;
    sum = {1'b0, move_m} + {1'b0, move_c};
    nl_m = boat_side ? missionary_left + move_m : missionary_left - move_m;
    nl_c = boat_side ? cannibal_left + move_c : cannibal_left - move_c;
    nr_m = NP - nl_m;
    nr_c = NP - nl_c;
    cap_bad = sum == '0 || sum > (W+1)'(BOAT_CAP);
    short_bad = move_m > dep_m || move_c > dep_c;
    unsafe_bad = (nl_m != '0 && nl_c > nl_m) || (nr_m != '0 && nr_c > nr_m);
    legal = !(cap_bad || short_bad || unsafe_bad);
  end
  assign take = move_valid && move_ready;
  assign finish = state == DONE;
  assign error = state == FAIL;
`ifdef RCC_UNDO_EN
  localparam int PW = HIST_DEPTH > 1 ? $clog2(HIST_DEPTH) : 1;
  localparam int FW = $clog2(HIST_DEPTH + 1);
  logic [2*W-1:0] hist [HIST_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [FW-1:0] fill;
  assign move_ready = state == PLAY && !undo;
  assign undo_clr = undo && state == FAIL;
  assign undo_pop = undo && state == PLAY && fill != '0;
  assign rp = wp == '0 ? PW'(HIST_DEPTH - 1) : wp - PW'(1);
  assign {um, uc} = hist[rp];
  // circular LIFO: once full, new pushes overwrite the oldest entry
  always_ff @(posedge clk)
    if (!reset) begin
      wp <= '0;
      fill <= '0;
    end else if (undo_pop) begin
      wp <= rp;
      fill <= fill - FW'(1);
    end else if (take && legal) begin
      hist[wp] <= {move_m, move_c};
      wp <= wp == PW'(HIST_DEPTH - 1) ? '0 : wp + PW'(1);
      fill <= fill == FW'(HIST_DEPTH) ? fill : fill + FW'(1);
    end
`else
  assign move_ready = state == PLAY;
  assign undo_clr = 1'b0;
  assign undo_pop = 1'b0;
  assign um = '0;
  assign uc = '0;
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      missionary_left <= NP;
      cannibal_left <= NP;
      boat_side <= 1'b0;
      move_count <= '0;
      err_code <= 2'd0;
      state <= PLAY;
    end else if (undo_clr) begin
      err_code <= 2'd0;
      state <= PLAY;
    end else if (undo_pop) begin
      missionary_left <= boat_side ? missionary_left + um : missionary_left - um;
      cannibal_left <= boat_side ? cannibal_left + uc : cannibal_left - uc;
      boat_side <= !boat_side;
      move_count <= move_count == '0 ? move_count : move_count - CNT_W'(1);
    end else if (take) begin
      if (!legal) begin
        state <= FAIL;
        err_code <= cap_bad ? 2'd1 : short_bad ? 2'd2 : 2'd3;
      end else begin
        missionary_left <= nl_m;
        cannibal_left <= nl_c;
        boat_side <= !boat_side;
        move_count <= &move_count ? move_count : move_count + CNT_W'(1);
        if (nl_m == '0 && nl_c == '0) state <= DONE;
      end
    end
endmodule

// File: tb/tb_river_crossing_checker.sv
// tb_river_crossing_checker: directed and random moves checked against an integer model of the puzzle rules
module tb_river_crossing_checker;
  localparam int N = 3, CAP = 2, CW = 6, HD = 16, W = $clog2(N + 1);
  logic clk = 1'b0, reset = 1'b0, move_valid = 1'b0, undo = 1'b0;
  logic [W-1:0] move_m = '0, move_c = '0;
  logic move_ready, boat_side, finish, error;
  logic [W-1:0] missionary_left, cannibal_left;
  logic [CW-1:0] move_count;
  logic [1:0] err_code;
  int checks = 0, failures = 0;
  int lm, lc, side, cnt, st, ec;
  int hist[$];
  int cm[11] = '{0, 0, 0, 0, 2, 1, 2, 0, 0, 0, 0};
  int cc[11] = '{2, 1, 2, 1, 0, 1, 0, 1, 2, 1, 2};
  always #5 clk = ~clk;
  river_crossing_checker #(.N_PAIRS(N), .BOAT_CAP(CAP), .CNT_W(CW), .HIST_DEPTH(HD)) dut (
    .clk(clk), .reset(reset),
`ifdef RCC_UNDO_EN
    .undo(undo),
`endif
    .move_valid(move_valid), .move_ready(move_ready), .move_m(move_m), .move_c(move_c),
    .missionary_left(missionary_left), .cannibal_left(cannibal_left), .boat_side(boat_side),
    .move_count(move_count), .finish(finish), .error(error), .err_code(err_code));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model(input int v, input int m, input int c, input int u);
    int dm, dc, nlm, nlc, nrm, nrc, e, h;
    if (reset == 1'b0) begin
      lm = N; lc = N; side = 0; cnt = 0; st = 0; ec = 0;
      hist.delete();
    end else if (u != 0 && st == 2) begin
      st = 0; ec = 0;
    end else if (u != 0 && st == 0) begin
      if (hist.size() > 0) begin
        h = hist.pop_back();
        lm = side ? lm + h / 16 : lm - h / 16;
        lc = side ? lc + h % 16 : lc - h % 16;
        side = 1 - side;
        cnt = cnt > 0 ? cnt - 1 : 0;
      end
    end else if (v != 0 && st == 0) begin
      dm = side ? N - lm : lm;
      dc = side ? N - lc : lc;
      nlm = side ? lm + m : lm - m;
      nlc = side ? lc + c : lc - c;
      nrm = N - nlm;
      nrc = N - nlc;
      e = (m + c == 0 || m + c > CAP) ? 1 : (m > dm || c > dc) ? 2 :
          ((nlm > 0 && nlc > nlm) || (nrm > 0 && nrc > nrm)) ? 3 : 0;
      if (e != 0) begin
        st = 2; ec = e;
      end else begin
        lm = nlm; lc = nlc; side = 1 - side;
        cnt = cnt < (1 << CW) - 1 ? cnt + 1 : cnt;
        hist.push_back(m * 16 + c);
        if (hist.size() > HD) void'(hist.pop_front());
        if (lm == 0 && lc == 0) st = 1;
      end
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".m_left"}, missionary_left, lm);
    check({tag, ".c_left"}, cannibal_left, lc);
    check({tag, ".side"}, boat_side, side);
    check({tag, ".count"}, move_count, cnt);
    check({tag, ".finish"}, finish, st == 1);
    check({tag, ".error"}, error, st == 2);
    check({tag, ".err_code"}, err_code, ec);
    check({tag, ".ready"}, move_ready, st == 0 && undo == 1'b0);
  endtask
  task automatic step(input int v, input int m, input int c, input int u, input string tag);
    move_valid = v[0]; move_m = W'(m); move_c = W'(c); undo = u[0];
    @(posedge clk);
    model(v, m, c, u);
    #1 check_all(tag);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    step(1, 0, 1, 0, "reset");
    reset = 1'b1;
  endtask
  initial begin
    do_reset();
    check("rst_m_left", missionary_left, 3);
    check("rst_count", move_count, 0);
    check("rst_ready", move_ready, 1);
    for (int i = 0; i < 11; i++) step(1, cm[i], cc[i], 0, "classic");
    check("classic_m_left", missionary_left, 0);
    check("classic_c_left", cannibal_left, 0);
    check("classic_side", boat_side, 1);
    check("classic_count", move_count, 11);
    check("classic_finish", finish, 1);
    check("classic_ready", move_ready, 0);
    check("classic_error", error, 0);
    repeat (5) step(1, 0, 1, 0, "done_hold");
    check("hold_count", move_count, 11);
    do_reset();
    step(1, 2, 1, 0, "capacity");
    check("cap_code", err_code, 1);
    check("cap_m_left", missionary_left, 3);
    check("cap_count", move_count, 0);
    do_reset();
    step(1, 0, 0, 0, "empty_boat");
    check("empty_code", err_code, 1);
    do_reset();
    step(1, 1, 0, 0, "unsafe");
    check("unsafe_code", err_code, 3);
    check("unsafe_c_left", cannibal_left, 3);
    do_reset();
    step(1, 0, 2, 0, "short_a");
    step(1, 1, 0, 0, "short_b");
    check("short_code", err_code, 2);
    check("short_c_left", cannibal_left, 1);
    check("short_count", move_count, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, cm[i], cc[i], 0, "mid_game");
    do_reset();
    check("midrst_c_left", cannibal_left, 3);
    check("midrst_count", move_count, 0);
    check("midrst_side", boat_side, 0);
    repeat (70) step(1, 0, 1, 0, "shuttle");
    check("sat_count", move_count, 63);
`ifdef RCC_UNDO_EN
    do_reset();
    step(1, 0, 2, 0, "undo_a");
    step(1, 0, 1, 0, "undo_b");
    step(0, 0, 0, 1, "undo_pop");
    check("undo_c_left", cannibal_left, 1);
    check("undo_side", boat_side, 1);
    check("undo_count", move_count, 1);
    step(1, 1, 0, 0, "undo_short");
    check("undo_short_code", err_code, 2);
    step(0, 0, 0, 1, "undo_clear");
    check("undo_clear_code", err_code, 0);
    check("undo_clear_c_left", cannibal_left, 1);
    step(0, 0, 0, 0, "undo_play");
    check("undo_play_ready", move_ready, 1);
`endif
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 40) == 0 || (st != 0 && $urandom_range(0, 3) == 0)) reset = 1'b0;
`ifdef RCC_UNDO_EN
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 6) == 0, "random");
`else
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 2), 0, "random");
`endif
      reset = 1'b1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
